// File: rtl/note_recorder_pkg.sv
// Shared types and sizing for the note recorder: note code width, slot count,
// packed-word width, recorder FSM states and the slot/count index types.
package note_recorder_pkg;

  localparam int NOTE_W    = 4;
  localparam int MAX_NOTES = 8;
  localparam int DATA_W    = NOTE_W * MAX_NOTES;
  localparam int IDX_W     = 4;
  localparam int CNT_W     = $clog2(MAX_NOTES) + 1;

  typedef logic [NOTE_W-1:0]            note_t;
  typedef logic [$clog2(MAX_NOTES)-1:0] slot_idx_t;
  typedef logic [CNT_W-1:0]             count_t;

  localparam note_t NOTE_REST = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } rec_state_t;

  // Slot index of a count value, zero-extended to the index port width.
  function automatic logic [IDX_W-1:0] to_index(count_t c);
    return IDX_W'(slot_idx_t'(c));
  endfunction

endpackage

// File: rtl/note_recorder_if.sv
// Bus from the recorder to the answer/playback store: packed notes, indices
// and the one-cycle write strobe.
interface note_recorder_if;
  import note_recorder_pkg::*;

  logic [DATA_W-1:0] data_out;
  logic [IDX_W-1:0]  max_index;
  logic [IDX_W-1:0]  cur_index;
  logic              write_enable;

  modport master (output data_out, output max_index, output cur_index, output write_enable);
  modport slave  (input  data_out, input  max_index, input  cur_index, input  write_enable);
endinterface

// File: rtl/note_recorder_debouncer.sv
// Keypad debouncer: accepts a code once it has been stable for DEBOUNCE_CYC
// samples, then requires DEBOUNCE_CYC consecutive rest samples before arming
// again, so a held key never repeats.
//
//  state   | meaning
//  IDLE    | no key down, ready for a new press
//  PRESS   | key down, counting stability of the latched code
//  RELEASE | note accepted, waiting for a stable release
module key_debouncer
  import note_recorder_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  clear,
  input  note_t key_in,
  output logic  acc_pulse,
  output note_t acc_code,
  output logic  released,
  output logic  in_press
);

  localparam int TMR_W = $clog2(DEBOUNCE_CYC + 1);
  // The sample that enters PRESS already counts as the first stable one.
  localparam logic [TMR_W-1:0] PRESS_LOAD = TMR_W'(DEBOUNCE_CYC - 2);
  localparam logic [TMR_W-1:0] REL_LOAD   = TMR_W'(DEBOUNCE_CYC - 1);

  rec_state_t       state, state_nxt;
  logic [TMR_W-1:0] tmr;
  note_t            code;
  logic             key_zero, key_same, tmr_done;
  logic             load_press, load_rel, dec, accept;

  assign key_zero = (key_in == NOTE_REST);
  assign key_same = (key_in == code);
  assign tmr_done = (tmr == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; clear always returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (!key_zero) state_nxt = PRESS;
        PRESS:   if (key_zero) state_nxt = IDLE;
                 else if (key_same && tmr_done) state_nxt = RELEASE;
        RELEASE: if (key_zero && tmr_done) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Timer/code controls and the accept decision for the current state.
  always_comb begin
    load_press = 1'b0;
    load_rel   = 1'b0;
    dec        = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: load_press = !key_zero;
      PRESS: begin
        if (!key_zero) begin
          if (!key_same) begin
            load_press = 1'b1;
          end else if (tmr_done) begin
            load_rel = 1'b1;
            accept   = !clear;
          end else begin
            dec = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (!key_zero)     load_rel = 1'b1;
        else if (!tmr_done) dec     = 1'b1;
      end
      default: ;
    endcase
  end

  // Stability down-counter, latched code and registered accept pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmr       <= '0;
      code      <= NOTE_REST;
      acc_pulse <= 1'b0;
    end else begin
      acc_pulse <= accept;
      if (load_press) begin
        code <= key_in;
        tmr  <= PRESS_LOAD;
      end else if (load_rel) begin
        tmr <= REL_LOAD;
      end else if (dec) begin
        tmr <= tmr - 1'b1;
      end
    end
  end

  assign acc_code = code;
  assign released = (state == IDLE);
  assign in_press = (state == PRESS);

endmodule

// File: rtl/note_recorder.sv
// Note recorder top: packs debounced notes into 8 x 4-bit slots and publishes
// the word to the answer store with a one-cycle write strobe on a commit edge.
// Build option AUTO_COMMIT_EN: strobe automatically once the 8th note lands.
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  note_t            key_in,
  input  logic             clear,
  input  logic             commit,
  note_recorder_if.master  ans,
  output logic             full,
  output logic             busy
);

  count_t count;
  logic   commit_q, pending;
  logic   commit_rise, commit_req, fire, auto_fire;
  logic   acc_pulse, released, in_press;
  note_t  acc_code;

  key_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .key_in    (key_in),
    .acc_pulse (acc_pulse),
    .acc_code  (acc_code),
    .released  (released),
    .in_press  (in_press)
  );

  assign full        = (count == CNT_W'(MAX_NOTES));
  assign busy        = !released;
  assign commit_rise = commit && !commit_q;
  // A commit edge seen mid-press is held until the press resolves.
  assign commit_req  = commit_rise || pending;
  assign fire        = commit_req && !in_press;

`ifdef AUTO_COMMIT_EN
  assign auto_fire = acc_pulse && (count == CNT_W'(MAX_NOTES - 1));
`else
  assign auto_fire = 1'b0;
`endif

  // Packing, indices and commit strobe; clear dominates commit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ans.data_out     <= '0;
      ans.max_index    <= '0;
      ans.cur_index    <= '0;
      ans.write_enable <= 1'b0;
      count            <= '0;
      commit_q         <= 1'b0;
      pending          <= 1'b0;
    end else if (clear) begin
      ans.data_out     <= '0;
      ans.max_index    <= '0;
      ans.cur_index    <= '0;
      ans.write_enable <= 1'b0;
      count            <= '0;
      commit_q         <= commit;
      pending          <= 1'b0;
    end else begin
      commit_q         <= commit;
      pending          <= commit_req && in_press;
      ans.write_enable <= (fire && (count != '0)) || auto_fire;
      if (acc_pulse && !full) begin
        for (int i = 0; i < MAX_NOTES; i++) begin
          if (count == CNT_W'(i)) ans.data_out[i*NOTE_W +: NOTE_W] <= acc_code;
        end
        ans.cur_index <= to_index(count);
        ans.max_index <= to_index(count);
        count         <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder with a short debounce window: directed scenarios
// plus randomized key/commit/clear traffic against a run-length/queue model.
module tb_note_recorder;
  import note_recorder_pkg::*;

  localparam int DEB = 4;

  logic  clk = 1'b0;
  logic  reset_n;
  note_t key_in;
  logic  clear, commit;
  logic  full, busy;

  note_recorder_if ans();

  note_recorder #(.DEBOUNCE_CYC(DEB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .key_in  (key_in),
    .clear   (clear),
    .commit  (commit),
    .ans     (ans),
    .full    (full),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int we_seen = 0;

  // Reference model: accepted notes as a queue, debounce as run lengths.
  int m_notes[$];
  int m_phase;       // 0 idle, 1 key down, 2 waiting for release
  int m_code, m_run, m_zrun, m_acc_note;
  bit m_acc_pend, m_prev_commit, m_pend, m_we;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rise, req;
    if (!reset_n) begin
      m_notes.delete();
      m_phase = 0; m_acc_pend = 0; m_prev_commit = 0; m_pend = 0; m_we = 0;
    end else if (clear) begin
      m_notes.delete();
      m_phase = 0; m_acc_pend = 0; m_prev_commit = commit; m_pend = 0; m_we = 0;
    end else begin
      rise = commit && !m_prev_commit;
      m_prev_commit = commit;
      req  = rise || m_pend;
      m_we   = req && (m_phase != 1) && (m_notes.size() > 0);
      m_pend = req && (m_phase == 1);
`ifdef AUTO_COMMIT_EN
      if (m_acc_pend && m_notes.size() == MAX_NOTES - 1) m_we = 1;
`endif
      if (m_acc_pend) begin
        if (m_notes.size() < MAX_NOTES) m_notes.push_back(m_acc_note);
        m_acc_pend = 0;
      end
      case (m_phase)
        0: if (key_in != 0) begin m_phase = 1; m_code = int'(key_in); m_run = 1; end
        1: begin
          if (key_in == 0) m_phase = 0;
          else if (int'(key_in) != m_code) begin m_code = int'(key_in); m_run = 1; end
          else begin
            m_run++;
            if (m_run == DEB) begin
              m_acc_pend = 1; m_acc_note = m_code; m_phase = 2; m_zrun = 0;
            end
          end
        end
        default: begin
          if (key_in == 0) begin
            m_zrun++;
            if (m_zrun == DEB) m_phase = 0;
          end else m_zrun = 0;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    logic [31:0] d;
    int n;
    d = '0;
    n = m_notes.size();
    for (int i = 0; i < n; i++) d[4*i +: 4] = 4'(m_notes[i]);
    check_eq("data_out", ans.data_out, d);
    check_eq("max_index", 32'(ans.max_index), (n > 0) ? 32'(n - 1) : 32'd0);
    check_eq("cur_index", 32'(ans.cur_index), (n > 0) ? 32'(n - 1) : 32'd0);
    check_eq("full", 32'(full), 32'(n == MAX_NOTES));
    check_eq("busy", 32'(busy), 32'(m_phase != 0));
    check_eq("write_enable", 32'(ans.write_enable), 32'(m_we));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (ans.write_enable === 1'b1) we_seen++;
  endtask

  task automatic press(int k, int hold, int rel);
    key_in = 4'(k);
    repeat (hold) tick();
    key_in = '0;
    repeat (rel) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; key_in = 4'd5; clear = 1'b0; commit = 1'b0;
    m_phase = 0; m_code = 0; m_run = 0; m_zrun = 0; m_acc_note = 0;
    m_acc_pend = 0; m_prev_commit = 0; m_pend = 0; m_we = 0;
    repeat (2) tick();
    check_eq("rst_data", ans.data_out, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_we", 32'(ans.write_enable), 32'd0);
    reset_n = 1'b1; key_in = '0;
    repeat (2) tick();

    // three notes then a commit
    press(3, 6, 6); press(7, 6, 6); press(1, 6, 6);
    check_eq("seq_data", ans.data_out, 32'h0000_0173);
    check_eq("seq_cur", 32'(ans.cur_index), 32'd2);
    check_eq("seq_max", 32'(ans.max_index), 32'd2);
    we_seen = 0;
    commit = 1'b1;
    tick();
    check_eq("commit_we", 32'(ans.write_enable), 32'd1);
    check_eq("commit_data", ans.data_out, 32'h0000_0173);
    check_eq("commit_max", 32'(ans.max_index), 32'd2);
    commit = 1'b0;
    repeat (3) tick();
    check_eq("commit_pulses", 32'(we_seen), 32'd1);

    // short press ignored, code change restarts the count
    do_clear();
    press(9, 2, 6);
    check_eq("short_press", ans.data_out, 32'h0);
    key_in = 4'd4; repeat (2) tick();
    press(6, 5, 6);
    check_eq("restart_data", ans.data_out, 32'h0000_0006);
    check_eq("restart_cur", 32'(ans.cur_index), 32'd0);

    // overfill: nine presses, ninth discarded
    do_clear();
    we_seen = 0;
    for (int k = 1; k <= 9; k++) press(k, 6, 6);
    check_eq("fill_data", ans.data_out, 32'h8765_4321);
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_cur", 32'(ans.cur_index), 32'd7);
`ifdef AUTO_COMMIT_EN
    check_eq("auto_pulses", 32'(we_seen), 32'd1);
`else
    check_eq("auto_pulses", 32'(we_seen), 32'd0);
`endif
    commit = 1'b1; tick();
    check_eq("full_commit_we", 32'(ans.write_enable), 32'd1);
    commit = 1'b0; tick();

    // commit on an empty buffer, then commit held long
    do_clear();
    commit = 1'b1; tick();
    check_eq("empty_commit_we", 32'(ans.write_enable), 32'd0);
    commit = 1'b0; tick();
    press(2, 6, 6); press(5, 6, 6); press(8, 6, 6);
    we_seen = 0;
    commit = 1'b1;
    repeat (10) tick();
    commit = 1'b0;
    tick();
    check_eq("held_commit_pulses", 32'(we_seen), 32'd1);

    // clear and commit together: clear wins
    we_seen = 0;
    clear = 1'b1; commit = 1'b1;
    tick();
    check_eq("clr_commit_we", 32'(ans.write_enable), 32'd0);
    check_eq("clr_commit_data", ans.data_out, 32'h0);
    check_eq("clr_commit_cur", 32'(ans.cur_index), 32'd0);
    check_eq("clr_commit_max", 32'(ans.max_index), 32'd0);
    clear = 1'b0;
    repeat (2) tick();
    commit = 1'b0;
    tick();
    check_eq("clr_commit_pulses", 32'(we_seen), 32'd0);

    // reset in the middle of a debounce
    key_in = 4'd2; repeat (3) tick();
    reset_n = 1'b0; tick();
    reset_n = 1'b1; key_in = '0; repeat (6) tick();
    check_eq("mid_rst_data", ans.data_out, 32'h0);

    // randomized traffic
    for (int s = 0; s < 250; s++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        reset_n = 1'b0; tick(); reset_n = 1'b1;
      end else if (r < 8) begin
        clear = 1'b1; tick(); clear = 1'b0;
      end
      key_in = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      commit = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 7)) tick();
      key_in = '0;
      repeat ($urandom_range(0, 6)) tick();
    end
    commit = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
